// File: rtl/vx_mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQS clients, with per-client pending throttle; optional perf counters under MEM_ARB_PERF_EN.
// Latency: request accepted at cycle N appears on mem_req_* at N+1; response demux is combinational (0 cycles).
// Backpressure: the output buffer holds while full and !mem_req_ready (all req_ready low); mem_rsp_ready follows rsp_ready of the addressed client.
module vx_mem_req_arbiter #(
   parameter int NUM_REQS    = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int TAG_WIDTH   = 8,
   parameter int MAX_PENDING = 4,
   localparam int IDX_W         = $clog2(NUM_REQS),
   localparam int MEM_TAG_WIDTH = TAG_WIDTH + IDX_W,
   localparam int BE_W          = DATA_WIDTH / 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQS-1:0]            req_valid,
   input  logic [NUM_REQS-1:0]            req_rw,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQS*BE_W-1:0]       req_byteen,
   input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
   output logic [NUM_REQS-1:0]            req_ready,
   output logic [NUM_REQS-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]          rsp_data,
   output logic [TAG_WIDTH-1:0]           rsp_tag,
   input  logic [NUM_REQS-1:0]            rsp_ready,
   output logic                           mem_req_valid,
   output logic                           mem_req_rw,
   output logic [ADDR_WIDTH-1:0]          mem_req_addr,
   output logic [DATA_WIDTH-1:0]          mem_req_data,
   output logic [BE_W-1:0]                mem_req_byteen,
   output logic [MEM_TAG_WIDTH-1:0]       mem_req_tag,
   input  logic                           mem_req_ready,
   input  logic                           mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]          mem_rsp_data,
   input  logic [MEM_TAG_WIDTH-1:0]       mem_rsp_tag,
   output logic                           mem_rsp_ready,
`ifdef MEM_ARB_PERF_EN
   output logic [31:0]                    perf_stall_cycles,
   output logic [31:0]                    perf_reqs,
`endif
   output logic                           busy
);

   localparam int CNT_W = $clog2(MAX_PENDING + 1);

   typedef struct packed {
      logic                     rw;
      logic [ADDR_WIDTH-1:0]    addr;
      logic [DATA_WIDTH-1:0]    data;
      logic [BE_W-1:0]          byteen;
      logic [MEM_TAG_WIDTH-1:0] tag;
   } mem_req_t;

   mem_req_t             req_pkt [NUM_REQS];
   mem_req_t             sel_req;
   mem_req_t             buf_q;
   logic                 buf_vld;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     grant_idx;
   logic [IDX_W-1:0]     cand;
   logic                 grant_vld;
   logic                 can_load;
   logic                 accept;
   logic [CNT_W-1:0]     pend [NUM_REQS];
   logic [NUM_REQS-1:0]  eligible;
   logic [NUM_REQS-1:0]  pend_nz;
   logic [NUM_REQS-1:0]  pend_inc;
   logic [NUM_REQS-1:0]  pend_dec;
   logic [NUM_REQS-1:0]  rsp_sel;
   logic [IDX_W-1:0]     rsp_idx;
   logic                 idx_ok;

   assign rsp_idx = mem_rsp_tag[MEM_TAG_WIDTH-1 -: IDX_W];
   assign idx_ok  = int'(rsp_idx) < NUM_REQS;

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_lane
      assign req_pkt[g] = '{rw:     req_rw[g],
                            addr:   req_addr[g*ADDR_WIDTH +: ADDR_WIDTH],
                            data:   req_data[g*DATA_WIDTH +: DATA_WIDTH],
                            byteen: req_byteen[g*BE_W +: BE_W],
                            tag:    {IDX_W'(g), req_tag[g*TAG_WIDTH +: TAG_WIDTH]}};
      assign pend_nz[g]   = pend[g] != '0;
      assign eligible[g]  = req_valid[g] && (pend[g] < CNT_W'(MAX_PENDING));
      assign req_ready[g] = accept && (grant_idx == IDX_W'(g));
      assign pend_inc[g]  = req_ready[g];
      assign rsp_sel[g]   = rsp_idx == IDX_W'(g);
      assign rsp_valid[g] = mem_rsp_valid && rsp_sel[g];
      // A response with the count already at 0 is delivered but never underflows it.
      assign pend_dec[g]  = rsp_valid[g] && rsp_ready[g] && pend_nz[g];
   end

   // Scan from the round-robin pointer, wrapping, and take the first eligible client.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      sel_req   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQS);
         if (!grant_vld && eligible[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
            sel_req   = req_pkt[cand];
         end
      end
   end

   assign can_load = !buf_vld || mem_req_ready;
   assign accept   = grant_vld && can_load;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_vld <= 1'b0;
         buf_q   <= '0;
         rr_ptr  <= '0;
      end else if (accept) begin
         buf_vld <= 1'b1;
         buf_q   <= sel_req;
         rr_ptr  <= IDX_W'((int'(grant_idx) + 1) % NUM_REQS);
      end else if (mem_req_ready) begin
         buf_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQS; i++) pend[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (pend_inc[i] && !pend_dec[i])      pend[i] <= pend[i] + CNT_W'(1);
            else if (pend_dec[i] && !pend_inc[i]) pend[i] <= pend[i] - CNT_W'(1);
         end
      end
   end

   assign mem_req_valid  = buf_vld;
   assign mem_req_rw     = buf_q.rw;
   assign mem_req_addr   = buf_q.addr;
   assign mem_req_data   = buf_q.data;
   assign mem_req_byteen = buf_q.byteen;
   assign mem_req_tag    = buf_q.tag;

   assign rsp_data      = mem_rsp_data;
   assign rsp_tag       = mem_rsp_tag[TAG_WIDTH-1:0];
   // Out-of-range indices are swallowed so the memory side never stalls on them.
   assign mem_rsp_ready = !idx_ok || |(rsp_ready & rsp_sel);
   assign busy          = buf_vld || |pend_nz;

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_cycles <= '0;
         perf_reqs         <= '0;
      end else begin
         if (buf_vld && !mem_req_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (accept)                    perf_reqs         <= perf_reqs + 32'd1;
      end
   end
`endif

   assert property (@(posedge clk) disable iff (!reset) mem_rsp_valid |-> idx_ok)
      else $error("vx_mem_req_arbiter: response index out of range");

endmodule

// File: tb/tb_vx_mem_req_arbiter.sv
// Directed bench for vx_mem_req_arbiter: an integer/queue-level reference model checked every cycle,
// plus hand-computed expectations for arbitration order, backpressure, response demux, throttle and reset.
module tb_vx_mem_req_arbiter;

   localparam int N    = 4;
   localparam int MAXP = 4;

   logic         clk;
   logic         reset;
   logic [3:0]   req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
   logic [127:0] req_addr, req_data;
   logic [15:0]  req_byteen;
   logic [31:0]  req_tag;
   logic [31:0]  rsp_data;
   logic [7:0]   rsp_tag;
   logic         mem_req_valid, mem_req_rw, mem_req_ready;
   logic [31:0]  mem_req_addr, mem_req_data;
   logic [3:0]   mem_req_byteen;
   logic [9:0]   mem_req_tag;
   logic         mem_rsp_valid, mem_rsp_ready;
   logic [31:0]  mem_rsp_data;
   logic [9:0]   mem_rsp_tag;
   logic         busy;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]  perf_stall_cycles, perf_reqs;
`endif

   int checks = 0;
   int errors = 0;
   bit run    = 1'b1;

   vx_mem_req_arbiter dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
      .req_byteen(req_byteen), .req_tag(req_tag), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
      .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
`ifdef MEM_ARB_PERF_EN
      .perf_stall_cycles(perf_stall_cycles), .perf_reqs(perf_reqs),
`endif
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_vld, m_rw;
   logic [31:0] m_addr, m_data;
   logic [3:0]  m_be;
   logic [9:0]  m_tag;
   int          m_rr;
   int          m_pend [N];
   int unsigned m_reqs, m_stalls;

   int          e_gnt, e_ridx;
   logic        e_gnt_vld, e_acc, e_fire, e_busy;
   logic [3:0]  e_req_ready, e_rsp_valid;

   always_comb begin
      e_gnt_vld = 1'b0;
      e_gnt     = 0;
      for (int k = 0; k < N; k++) begin
         if (!e_gnt_vld && req_valid[(m_rr + k) % N] && m_pend[(m_rr + k) % N] < MAXP) begin
            e_gnt_vld = 1'b1;
            e_gnt     = (m_rr + k) % N;
         end
      end
      e_acc       = e_gnt_vld && (!m_vld || mem_req_ready);
      e_req_ready = '0;
      if (e_acc) e_req_ready[e_gnt] = 1'b1;
      e_ridx      = int'(mem_rsp_tag[9:8]);
      e_rsp_valid = '0;
      e_rsp_valid[e_ridx] = mem_rsp_valid;
      e_fire      = mem_rsp_valid && rsp_ready[e_ridx];
      e_busy      = m_vld;
      for (int i = 0; i < N; i++) if (m_pend[i] > 0) e_busy = 1'b1;
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_vld <= 1'b0; m_rw <= 1'b0; m_addr <= '0; m_data <= '0; m_be <= '0; m_tag <= '0;
         m_rr <= 0; m_reqs <= 0; m_stalls <= 0;
         for (int i = 0; i < N; i++) m_pend[i] <= 0;
      end else begin
         if (e_acc) begin
            m_vld  <= 1'b1;
            m_rw   <= req_rw[e_gnt];
            m_addr <= req_addr[e_gnt*32 +: 32];
            m_data <= req_data[e_gnt*32 +: 32];
            m_be   <= req_byteen[e_gnt*4 +: 4];
            m_tag  <= {2'(e_gnt), req_tag[e_gnt*8 +: 8]};
            m_rr   <= (e_gnt + 1) % N;
            m_reqs <= m_reqs + 1;
         end else if (mem_req_ready) begin
            m_vld <= 1'b0;
         end
         if (m_vld && !mem_req_ready) m_stalls <= m_stalls + 1;
         for (int i = 0; i < N; i++)
            m_pend[i] <= m_pend[i] + ((e_acc && e_gnt == i) ? 1 : 0)
                                   - ((e_fire && e_ridx == i && m_pend[i] > 0) ? 1 : 0);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (run) begin
         chk("req_ready", req_ready, e_req_ready);
         chk("mem_req_valid", mem_req_valid, m_vld);
         if (m_vld) begin
            chk("mem_req_rw", mem_req_rw, m_rw);
            chk("mem_req_addr", mem_req_addr, m_addr);
            chk("mem_req_data", mem_req_data, m_data);
            chk("mem_req_byteen", mem_req_byteen, m_be);
            chk("mem_req_tag", mem_req_tag, m_tag);
         end
         chk("rsp_valid", rsp_valid, e_rsp_valid);
         chk("rsp_data", rsp_data, mem_rsp_data);
         chk("rsp_tag", rsp_tag, mem_rsp_tag[7:0]);
         chk("mem_rsp_ready", mem_rsp_ready, rsp_ready[e_ridx]);
         chk("busy", busy, e_busy);
`ifdef MEM_ARB_PERF_EN
         chk("perf_reqs", perf_reqs, m_reqs);
         chk("perf_stall_cycles", perf_stall_cycles, m_stalls);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic nx();
      @(negedge clk);
   endtask

   task automatic px();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = '0; mem_rsp_valid = 1'b0; rsp_ready = '0; mem_req_ready = 1'b1;
   endtask

   task automatic drain_all();
      for (int r = 0; r < 20; r++) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_tag   = {2'(r % 4), 8'(r)};
         mem_rsp_data  = 32'h5000_0000 + 32'(r);
         rsp_ready     = 4'hF;
         px();
      end
      idle();
   endtask

   int seq[$];

   initial begin
      reset = 1'b0;
      req_rw = 4'b0101;
      mem_rsp_tag = '0; mem_rsp_data = '0;
      for (int i = 0; i < N; i++) begin
         req_addr[i*32 +: 32]  = 32'h1000_0000 + 32'(i * 16);
         req_data[i*32 +: 32]  = 32'hDA7A_0000 + 32'(i);
         req_byteen[i*4 +: 4]  = 4'hF ^ 4'(i);
         req_tag[i*8 +: 8]     = 8'h10 + 8'(i);
      end
      idle();

      // reset state
      px(); px();
      nx();
      chk("rst_mem_req_valid", mem_req_valid, 1'b0);
      chk("rst_mem_req_addr", mem_req_addr, 32'h0);
      chk("rst_mem_req_tag", mem_req_tag, 10'h0);
      chk("rst_busy", busy, 1'b0);
      px();
      reset = 1'b1;

      // all four requesting: index order 0,1,2,3 repeating, 16 accepts then throttled
      req_valid = 4'hF;
      for (int c = 0; c < 20; c++) begin
         nx();
         if (mem_req_valid) seq.push_back(int'(mem_req_tag[9:8]));
         px();
      end
      nx();
      chk("s1_count", seq.size(), 16);
      for (int k = 0; k < 4; k++) chk("s1_order", seq[k], k);
      chk("s1_busy", busy, 1'b1);
      chk("s1_throttled", req_ready, 4'b0000);
      px();

      // response demux with rsp_ready low then high; requester 1 stays throttled meanwhile
      req_valid = 4'b0010; mem_rsp_valid = 1'b1; mem_rsp_tag = {2'd1, 8'hA5};
      mem_rsp_data = 32'hCAFE_F00D; rsp_ready = 4'b0000;
      nx();
      chk("s3a_rsp_valid", rsp_valid, 4'b0010);
      chk("s3a_rsp_tag", rsp_tag, 8'hA5);
      chk("s3a_mem_rsp_ready", mem_rsp_ready, 1'b0);
      chk("s3a_req_ready", req_ready, 4'b0000);
      px();
      rsp_ready = 4'b0010;
      nx();
      chk("s3b_rsp_valid", rsp_valid, 4'b0010);
      chk("s3b_rsp_tag", rsp_tag, 8'hA5);
      chk("s3b_mem_rsp_ready", mem_rsp_ready, 1'b1);
      chk("s3b_req_ready", req_ready, 4'b0000);
      px();
      mem_rsp_valid = 1'b0; rsp_ready = '0;
      nx();
      chk("s3c_req_ready", req_ready, 4'b0010);
      px();
      idle();
      drain_all();
      nx();
      chk("drain_busy", busy, 1'b0);
      px();

      // single requester with three backpressured cycles
      req_valid = 4'b0100; mem_req_ready = 1'b0;
      nx();
      chk("s2_first_accept", req_ready, 4'b0100);
      px();
      for (int c = 1; c <= 3; c++) begin
         req_addr[95:64] = 32'hBEEF_0000 + 32'(c);
         nx();
         chk("s2_hold_ready", req_ready, 4'b0000);
         chk("s2_hold_valid", mem_req_valid, 1'b1);
         chk("s2_hold_addr", mem_req_addr, 32'h1000_0020);
         chk("s2_hold_tag", mem_req_tag, 10'h212);
         px();
      end
      mem_req_ready = 1'b1;
      nx();
      chk("s2_next_accept", req_ready, 4'b0100);
      px();
      idle();
      req_addr[95:64] = 32'h1000_0020;
      drain_all();

      // same-cycle accept and retire for requester 0 at pend=3
      req_valid = 4'b0001;
      px(); px(); px();
      mem_rsp_valid = 1'b1; mem_rsp_tag = {2'd0, 8'h77}; rsp_ready = 4'b0001;
      nx();
      chk("s4_both_ready", req_ready, 4'b0001);
      px();
      mem_rsp_valid = 1'b0; rsp_ready = '0;
      nx();
      chk("s4_pend3_ready", req_ready, 4'b0001);
      px();
      nx();
      chk("s4_pend4_ready", req_ready, 4'b0000);
      px();
      idle();
      drain_all();

      // reset while buffer full with pend = 2,1,0,3
      req_valid = 4'b0001; px(); px();
      req_valid = 4'b0010; px();
      req_valid = 4'b1000; px(); px(); px();
      req_valid = '0; mem_req_ready = 1'b0;
      nx();
      chk("s5_full_valid", mem_req_valid, 1'b1);
      chk("s5_full_busy", busy, 1'b1);
      px();
      reset = 1'b0;
      nx();
      chk("s5_rst_valid", mem_req_valid, 1'b0);
      chk("s5_rst_busy", busy, 1'b0);
      chk("s5_rst_tag", mem_req_tag, 10'h0);
      px();
      reset = 1'b1; mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1; mem_rsp_tag = {2'd3, 8'h33}; mem_rsp_data = 32'h0BAD_BEEF; rsp_ready = 4'hF;
      nx();
      chk("s5_rsp_valid", rsp_valid, 4'b1000);
      chk("s5_rsp_ready", mem_rsp_ready, 1'b1);
      px();
      idle();
      nx();
      chk("s5_busy_after_rsp", busy, 1'b0);
      px();

      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
